// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider.
// Holds the FSM state encoding and the iteration counter width helper.
package div_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter width needed to count 0..w-1 iterations (w >= 2)
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/divider_subtractor.sv
// Ripple-borrow subtractor built from a chain of 1-bit full subtractors.
// Mirrors the full-adder chain of the companion ripple adder.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

module subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] borrow;

    assign borrow[0]  = 1'b0;
    assign borrow_out = borrow[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor u_fs (
            .a          (a[i]),
            .b          (b[i]),
            .borrow_in  (borrow[i]),
            .diff       (diff[i]),
            .borrow_out (borrow[i+1])
        );
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Returns quotient, remainder and a divide-by-zero flag with a done pulse.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // R[WIDTH] stays 0 after every step; it is kept only as headroom
    logic unused_r_msb;
    assign unused_r_msb = r[WIDTH];

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // Shift the next dividend bit into the partial remainder
    assign s = {r[WIDTH-1:0], q[WIDTH-1]};

    subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a          (s),
        .b          ({1'b0, d}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // Restore on borrow, otherwise accept the difference and set the bit
    always_comb begin
        r_next = borrow ? s : diff;
        q_next = {q[WIDTH-2:0], ~borrow};
    end

    // FSM, working registers and held results
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                IDLE, DONE: begin
                    if (start) begin
                        q   <= dividend;
                        d   <= divisor;
                        r   <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= CALC;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the 4-bit restoring divider.
// Covers latency, zero divisor, ignored start, back-to-back and reset.
module tb_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int tests;
    int fails;

    divider #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start in cycle 0, walk the expected busy window, stop in the done cycle
    task automatic run_div(input int a, input int b, input int eq,
                           input int er, input int ez, input string tag);
        start    = 1'b1;
        dividend = 4'(a);
        divisor  = 4'(b);
        tick();
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        if (b != 0) begin
            for (int c = 1; c <= 4; c++) begin
                chk({tag, " busy"}, int'(busy), 1);
                chk({tag, " done_lo"}, int'(done), 0);
                tick();
            end
        end
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " busy_lo"}, int'(busy), 0);
        chk({tag, " q"}, int'(quotient), eq);
        chk({tag, " r"}, int'(remainder), er);
        chk({tag, " dbz"}, int'(div_by_zero), ez);
    endtask

    initial begin
        int eq;
        int er;
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst q", int'(quotient), 0);
        chk("rst r", int'(remainder), 0);
        chk("rst dbz", int'(div_by_zero), 0);

        run_div(13, 4, 3, 1, 0, "13/4");
        tick();
        chk("13/4 pulse", int'(done), 0);
        run_div(15, 1, 15, 0, 0, "15/1");
        tick();
        run_div(7, 9, 0, 7, 0, "7/9");
        tick();
        run_div(15, 15, 1, 0, 0, "15/15");
        tick();
        run_div(0, 5, 0, 0, 0, "0/5");
        tick();
        run_div(9, 0, 15, 9, 1, "9/0");
        tick();
        chk("9/0 pulse", int'(done), 0);
        chk("9/0 busy", int'(busy), 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                eq = (b == 0) ? 15 : a / b;
                er = (b == 0) ? a : a % b;
                run_div(a, b, eq, er, (b == 0) ? 1 : 0,
                        $sformatf("sw %0d/%0d", a, b));
                if (b != 0) begin
                    chk($sformatf("id %0d/%0d", a, b),
                        int'(quotient) * b + int'(remainder), a);
                    chk($sformatf("rlt %0d/%0d", a, b),
                        int'(int'(remainder) < b), 1);
                end
                tick();
            end
        end

        // Start during CALC must be ignored
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd4;
        tick();
        start = 1'b0;
        tick();
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        tick();
        start = 1'b0;
        chk("ign busy3", int'(busy), 1);
        tick();
        chk("ign busy4", int'(busy), 1);
        tick();
        chk("ign done", int'(done), 1);
        chk("ign q", int'(quotient), 3);
        chk("ign r", int'(remainder), 1);
        tick();
        chk("ign idle", int'(done), 0);

        // Back-to-back: restart in the done cycle
        run_div(13, 4, 3, 1, 0, "b2b1");
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("b2b busy", int'(busy), 1);
            chk("b2b done_lo", int'(done), 0);
            chk("b2b hold q", int'(quotient), 3);
            chk("b2b hold r", int'(remainder), 1);
            tick();
        end
        chk("b2b done", int'(done), 1);
        chk("b2b q", int'(quotient), 4);
        chk("b2b r", int'(remainder), 2);
        tick();

        // Reset in cycle 3 of an operation
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst busy", int'(busy), 0);
        chk("mrst done", int'(done), 0);
        chk("mrst q", int'(quotient), 0);
        chk("mrst r", int'(remainder), 0);
        chk("mrst dbz", int'(div_by_zero), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mrst no done", int'(done), 0);
            chk("mrst idle", int'(busy), 0);
        end
        run_div(13, 4, 3, 1, 0, "after rst");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
